// File: rtl/pwm_duty_capture.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_capture
// Measures high time and full period of an asynchronous PWM line in CLK cycles.
// Revision: 1.0
// ============================================================================
module pwm_duty_capture #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] period_count,
    output logic             valid,
    output logic             timeout,
    output logic             busy
);

    // A single-flop synchronizer is never acceptable, so the depth is clamped.
    localparam int               C_SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [WIDTH-1:0] C_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_HIGH = 2'd1;
    localparam logic [1:0] C_ST_LOW  = 2'd2;

    logic [C_SYNC_N-1:0] sync_q;
    logic                pwm_d_q;
    logic                w_pwm_s;
    logic                w_rise;
    logic                w_fall;
    logic                w_pcnt_max;
    logic                w_meas;
    logic                w_expire;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] hcnt_q,   hcnt_d;
    logic [WIDTH-1:0] pcnt_q,   pcnt_d;
    logic [WIDTH-1:0] high_q,   high_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q,  valid_d;
    logic             timeout_q, timeout_d;

    assign w_pwm_s    = sync_q[C_SYNC_N-1];
    assign w_rise     = w_pwm_s & ~pwm_d_q;
    assign w_fall     = ~w_pwm_s & pwm_d_q;
    assign w_pcnt_max = (pcnt_q == C_MAX);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[C_SYNC_N-2:0], pwm_in};
            pwm_d_q <= w_pwm_s;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= C_ST_IDLE;
            hcnt_q    <= '0;
            pcnt_q    <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Edge events take priority over the MAX check, so a period of exactly
    // C_MAX cycles still completes as a normal measurement.
    always_comb begin
        state_d  = state_q;
        w_meas   = 1'b0;
        w_expire = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                if (w_rise) begin
                    state_d = C_ST_HIGH;
                end
            end
            C_ST_HIGH: begin
                if (w_fall) begin
                    state_d = C_ST_LOW;
                end else if (w_pcnt_max) begin
                    state_d  = C_ST_IDLE;
                    w_expire = 1'b1;
                end
            end
            C_ST_LOW: begin
                if (w_rise) begin
                    state_d = C_ST_HIGH;
                    w_meas  = 1'b1;
                end else if (w_pcnt_max) begin
                    state_d  = C_ST_IDLE;
                    w_expire = 1'b1;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                hcnt_d = w_rise ? C_ONE : '0;
                pcnt_d = w_rise ? C_ONE : '0;
            end
            C_ST_HIGH: begin
                if (w_fall) begin
                    pcnt_d = pcnt_q + C_ONE;
                end else if (!w_pcnt_max) begin
                    hcnt_d = hcnt_q + C_ONE;
                    pcnt_d = pcnt_q + C_ONE;
                end
            end
            C_ST_LOW: begin
                if (w_rise) begin
                    hcnt_d = C_ONE;
                    pcnt_d = C_ONE;
                end else if (!w_pcnt_max) begin
                    pcnt_d = pcnt_q + C_ONE;
                end
            end
            default: begin
                hcnt_d = '0;
                pcnt_d = '0;
            end
        endcase

        if (w_meas) begin
            high_d   = hcnt_q;
            period_d = pcnt_q;
            valid_d  = 1'b1;
        end

        // A line still high at expiry is reported as fully stuck high.
        if (w_expire) begin
            timeout_d = 1'b1;
            period_d  = C_MAX;
            high_d    = w_pwm_s ? C_MAX : hcnt_q;
            hcnt_d    = '0;
            pcnt_d    = '0;
        end
    end

    assign high_count   = high_q;
    assign period_count = period_q;
    assign valid        = valid_q;
    assign timeout      = timeout_q;
    assign busy         = (state_q == C_ST_HIGH) || (state_q == C_ST_LOW);

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_duty_capture
// Self-checking bench for pwm_duty_capture with a timestamp-based reference.
// Revision: 1.0
// ============================================================================
module tb_pwm_duty_capture;

    localparam int W    = 10;
    localparam int S    = 2;
    localparam int MAXC = (1 << W) - 1;
    localparam int HIST = 1 << 17;

    typedef struct packed {
        logic [W-1:0] h;
        logic [W-1:0] p;
    } meas_t;

    logic         CLK    = 1'b0;
    logic         reset  = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] high_count;
    logic [W-1:0] period_count;
    logic         valid;
    logic         timeout;
    logic         busy;

    int tests = 0;
    int fails = 0;

    meas_t vq[$];
    meas_t tq[$];

    pwm_duty_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: the line as seen after the synchronizer is the input sampled
    // S edges earlier; a measurement is the distance between edge timestamps.
    bit           samp [HIST];
    int           m_n   = 0;
    bit           m_trk = 1'b0;
    bit           m_hf  = 1'b0;
    int           m_tr  = 0;
    int           m_tf  = 0;
    logic [W-1:0] e_high    = '0;
    logic [W-1:0] e_period  = '0;
    bit           e_valid   = 1'b0;
    bit           e_timeout = 1'b0;

    function automatic bit lvl(input int n);
        return (n >= S) ? samp[n-S] : 1'b0;
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_n       <= 0;
            m_trk     <= 1'b0;
            m_hf      <= 1'b0;
            m_tr      <= 0;
            m_tf      <= 0;
            e_high    <= '0;
            e_period  <= '0;
            e_valid   <= 1'b0;
            e_timeout <= 1'b0;
        end else begin
            samp[m_n] <= pwm_in;
            m_n       <= m_n + 1;
            e_valid   <= 1'b0;
            e_timeout <= 1'b0;
            if (!m_trk) begin
                if (lvl(m_n) && !lvl(m_n - 1)) begin
                    m_trk <= 1'b1;
                    m_tr  <= m_n;
                    m_hf  <= 1'b0;
                end
            end else if (lvl(m_n) && !lvl(m_n - 1)) begin
                e_valid  <= 1'b1;
                e_high   <= W'(m_tf - m_tr);
                e_period <= W'(m_n - m_tr);
                m_tr     <= m_n;
                m_hf     <= 1'b0;
            end else if (!lvl(m_n) && lvl(m_n - 1)) begin
                m_hf <= 1'b1;
                m_tf <= m_n;
            end else if (m_n - m_tr == MAXC) begin
                e_timeout <= 1'b1;
                e_period  <= W'(MAXC);
                e_high    <= m_hf ? W'(m_tf - m_tr) : W'(MAXC);
                m_trk     <= 1'b0;
            end
        end
    end

    always @(posedge CLK) begin
        #2;
        chk("high_count",   int'(high_count),   int'(e_high));
        chk("period_count", int'(period_count), int'(e_period));
        chk("valid",        int'(valid),        int'(e_valid));
        chk("timeout",      int'(timeout),      int'(e_timeout));
        chk("busy",         int'(busy),         int'(m_trk));
        if (valid)   vq.push_back('{high_count, period_count});
        if (timeout) tq.push_back('{high_count, period_count});
    end

    task automatic drive(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_meas(input string name, input meas_t m, input int h, input int p);
        chk({name, "_high"},   int'(m.h), h);
        chk({name, "_period"}, int'(m.p), p);
    endtask

    initial begin
        // Reset sequence
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        drive(0, 50);
        chk("rst_high",   int'(high_count),   0);
        chk("rst_period", int'(period_count), 0);
        chk("rst_busy",   int'(busy),         0);
        chk("rst_nvalid", vq.size(),          0);
        chk("rst_ntmo",   tq.size(),          0);

        // Steady 300/700: first rise unreported
        vq.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 300);
            drive(0, 700);
        end
        chk("steady_nvalid", vq.size(), 3);
        for (int i = 0; i < vq.size(); i++) chk_meas("steady", vq[i], 300, 1000);
        chk("model_pin_high",   int'(e_high),   300);
        chk("model_pin_period", int'(e_period), 1000);

        // Shortened low phase, then minimum 1/1 pulses
        vq.delete();
        drive(1, 300);
        drive(0, 450);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1);
            drive(0, 1);
        end
        drive(0, 10);
        chk("min_nvalid", vq.size(), 21);
        if (vq.size() >= 2) begin
            chk_meas("min_prev",  vq[0], 300, 1000);
            chk_meas("min_mixed", vq[1], 300, 750);
        end
        for (int i = 2; i < vq.size(); i++) chk_meas("min_pulse", vq[i], 1, 2);

        // Stuck high
        vq.delete();
        tq.delete();
        drive(1, 1100);
        chk("sh_ntmo", tq.size(), 1);
        if (tq.size() >= 1) chk_meas("sh_tmo", tq[0], 1023, 1023);
        chk("sh_nvalid", vq.size(), 1);
        if (vq.size() >= 1) chk_meas("sh_last", vq[0], 1, 12);
        chk("sh_busy", int'(busy), 0);

        // Stuck low after a 200-cycle high phase
        vq.delete();
        tq.delete();
        drive(0, 50);
        drive(1, 200);
        drive(0, 1100);
        chk("sl_ntmo", tq.size(), 1);
        if (tq.size() >= 1) chk_meas("sl_tmo", tq[0], 200, 1023);
        chk("sl_nvalid", vq.size(), 0);
        chk("sl_busy",   int'(busy), 0);

        // Period boundary: 1023 reported, 1024 times out
        vq.delete();
        tq.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, 500);
            drive(0, 523);
        end
        drive(1, 500);
        drive(0, 1100);
        chk("bnd_nvalid", vq.size(), 3);
        for (int i = 0; i < vq.size(); i++) chk_meas("bnd_valid", vq[i], 500, 1023);
        chk("bnd_ntmo", tq.size(), 1);
        if (tq.size() >= 1) chk_meas("bnd_tmo", tq[0], 500, 1023);
        chk("bnd_busy", int'(busy), 0);

        // Randomized phases, occasionally stuck
        for (int i = 0; i < 30; i++) begin
            drive(1, ($urandom_range(0, 9) == 0) ? 1100 : int'($urandom_range(1, 500)));
            drive(0, ($urandom_range(0, 7) == 0) ? 1100 : int'($urandom_range(1, 500)));
        end
        drive(0, 1100);

        // Asynchronous reset 200 cycles into a high phase
        drive(0, 20);
        for (int i = 0; i < 2; i++) begin
            drive(1, 100);
            drive(0, 100);
        end
        drive(1, 200);
        chk("pre_rst_busy",   int'(busy),         1);
        chk("pre_rst_high",   int'(high_count),   100);
        chk("pre_rst_period", int'(period_count), 200);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_high",    int'(high_count),   0);
        chk("arst_period",  int'(period_count), 0);
        chk("arst_valid",   int'(valid),        0);
        chk("arst_timeout", int'(timeout),      0);
        chk("arst_busy",    int'(busy),         0);
        repeat (3) @(negedge CLK);
        vq.delete();
        tq.delete();
        reset = 1'b1;
        drive(1, 100);
        drive(0, 150);
        chk("post_rst_nvalid0", vq.size(), 0);
        drive(1, 80);
        drive(0, 80);
        drive(1, 5);
        drive(0, 10);
        chk("post_rst_nvalid", vq.size(), 2);
        if (vq.size() >= 2) begin
            chk_meas("post_rst_p1", vq[0], 100, 250);
            chk_meas("post_rst_p2", vq[1], 80, 160);
        end
        chk("post_rst_ntmo", tq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- Receive-side counterpart of the 10-bit DPWM generator (programmable counter plus comparator).
- Samples a PWM waveform and measures two values per period, counted in CLK cycles:
  - high time;
  - full period.
- Used for loop-back checking of the DPWM output and for closed-loop duty readback.
- Presents one registered measurement per PWM period with a one-cycle valid strobe.
- Flags a stuck line (0 % or 100 % duty) or an over-long period with a timeout strobe.

Parameters:
- WIDTH, 10, width of both measurement counters. MAX = 2^WIDTH-1 = 1023.
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchronizer. Minimum 2.

Ports:
- CLK  input  1  system clock. All logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- pwm_in  input  1  PWM waveform under measurement. It is asynchronous to CLK.
- high_count  output  WIDTH  CLK cycles the line was high in the last complete period.
- period_count  output  WIDTH  CLK cycles from rising edge to rising edge of the last complete period.
- valid  output  1  one-cycle strobe: high_count and period_count were just updated with a new measurement.
- timeout  output  1  one-cycle strobe: no rising edge arrived within MAX cycles.
- busy  output  1  high while in HIGH or LOW state, i.e. tracking a period.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears all synchronizer flops, the edge-detect flop and both counters.
  - high_count=0, period_count=0, valid=0, timeout=0, busy=0, state=IDLE.
  - Asserting reset mid-measurement discards the partial period. Outputs return to 0 immediately, without waiting for CLK.
- Synchronizer:
  - pwm_s is the output of a SYNC_STAGES-deep flop chain.
  - pwm_d is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_d.
  - fall = ~pwm_s & pwm_d.
- Internal counters: hcnt and pcnt, each WIDTH bits. Neither counter ever wraps; the timeout rule below prevents it.
- States: IDLE, HIGH, LOW.
- IDLE:
  - Counters held at 0.
  - On rise: hcnt<=1, pcnt<=1, go to HIGH.
  - The first partial period after reset or after a timeout is never reported.
- HIGH, checked in this priority order:
  - rise is impossible in this state.
  - If fall: pcnt<=pcnt+1, go to LOW.
  - Else if pcnt==MAX: timeout rule.
  - Else: hcnt<=hcnt+1, pcnt<=pcnt+1.
- LOW, checked in this priority order:
  - If rise:
    - high_count<=hcnt, period_count<=pcnt, valid<=1.
    - Restart with hcnt<=1, pcnt<=1, go to HIGH.
  - Else if pcnt==MAX: timeout rule.
  - Else: pcnt<=pcnt+1.
- Resulting counts: for a post-sync waveform high H cycles then low L cycles, the measurement is high_count=H and period_count=H+L.
- Limits:
  - Minimum measurable waveform is H=1, L=1, giving a period of 2.
  - A period of exactly MAX cycles is reported normally, because rise has priority over MAX in the same cycle.
- Timeout rule (period exceeds MAX):
  - timeout<=1 for one cycle; valid stays 0.
  - period_count<=MAX.
  - high_count<=MAX if pwm_s=1 (stuck high); high_count<=hcnt if pwm_s=0.
  - Go to IDLE.
  - Only one timeout strobe is issued per stuck event. IDLE issues none.
- Latency:
  - An edge on pwm_in reaches rise after SYNC_STAGES+1 CLK edges.
  - valid and the new counts appear on the same CLK edge that acts on rise.
  - valid and timeout are never high in the same cycle.
- Output registers hold their last value between updates.
- busy=1 exactly when state is HIGH or LOW.

Test Plan:
- Reset sequence:
  - Stimulus: hold reset=0 for 3 cycles, then release with pwm_in=0 for 50 cycles.
  - Required: all outputs 0, busy=0, no valid, no timeout.
- Steady PWM:
  - Stimulus: pwm_in high 300 / low 700 cycles, repeated 4 times.
  - Required: the first rising edge produces no valid. Each later rising edge produces valid with high_count=300, period_count=1000.
- Duty change and minimum pulse:
  - Stimulus: switch to high 1 / low 1 mid-stream.
  - Required: the first valid after the switch shows the mixed period: H=300, period_count=300+L_partial.
  - Required: the following valids show high_count=1, period_count=2 on every second cycle.
- Stuck high:
  - Stimulus: raise pwm_in and hold it high.
  - Required: exactly one timeout, 1023 cycles after the synced rise is acted on, with high_count=1023, period_count=1023.
  - Required: no further strobes, busy=0.
  - Stuck low behaves the same with high_count=H of the last high phase.
- Period boundary:
  - Stimulus: high 500 / low 523 (period 1023).
  - Required: valid with period_count=1023, no timeout.
  - Stimulus: high 500 / low 524.
  - Required: timeout, period_count=1023, high_count=500, then a return to IDLE.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously 200 cycles into a high phase.
  - Required: outputs clear immediately, without a CLK edge. After release, the next full period is reported only after a new rising edge plus one complete period.
